// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase scheduler.
// Holds the phase state encoding, preempt source encoding, lamp codes,
// approach indices, the latched preempt record and a one-hot helper.
package traffic_pkg;

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned DIR_W   = 2;
    localparam int unsigned NUM_DIR = 4;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        PREEMPT = 2'd3
    } state_t;

    // Encoding order is priority order: lower value wins.
    typedef enum logic [1:0] {
        SRC_EMRG   = 2'd0,
        SRC_ALERT1 = 2'd1,
        SRC_ALERT2 = 2'd2
    } src_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

    localparam logic [DIR_W-1:0] DIR_N = 2'd0;
    localparam logic [DIR_W-1:0] DIR_E = 2'd1;
    localparam logic [DIR_W-1:0] DIR_S = 2'd2;
    localparam logic [DIR_W-1:0] DIR_W_IDX = 2'd3;

    // Preempt source and target captured on PREEMPT entry.
    typedef struct packed {
        src_t             src;
        logic [DIR_W-1:0] dir;
    } preempt_t;

    function automatic logic [NUM_DIR-1:0] dir_onehot(input logic [DIR_W-1:0] d);
        dir_onehot = NUM_DIR'(1) << d;
    endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational round-robin picker.
// Scans ptr+1, ptr+2, ptr+3, ptr (mod 4) and returns the first requester.
//   ptr  : index of the approach served last
//   req  : per-approach demand, bit0=N .. bit3=W
//   next : chosen approach index (equals ptr when nothing requests)
//   any  : at least one requester
module traffic_rr_pick
    import traffic_pkg::*;
(
    input  logic [DIR_W-1:0]   ptr,
    input  logic [NUM_DIR-1:0] req,
    output logic [DIR_W-1:0]   next,
    output logic               any
);

    logic [DIR_W-1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        next = ptr;
        idx  = ptr;
        any  = |req;
        for (int i = NUM_DIR; i >= 1; i--) begin
            idx = ptr + DIR_W'(i);
            if (req[idx]) begin
                next = idx;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-way intersection phase scheduler.
// Serves one approach at a time in round-robin order among approaches with
// sensor demand, with minimum-green gap-out, yellow and all-red clearance,
// and emergency / police preemption.
//   clk, rst            : clock, asynchronous active-low reset
//   sensor_*            : per-approach demand levels
//   emrg, alert1, alert2: preempt requests (priority in that order)
//   pre_dir             : preempt target approach
//   grant, lamp         : served approach (one-hot) and its lamp code
//   all_red             : nothing green or yellow
//   ambulance, police   : active preempt flags
//   count               : current state down-counter
//   phase_done          : one-cycle pulse on YELLOW -> ALL_RED
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_T   = 20,
    parameter int unsigned MIN_T     = 6,
    parameter int unsigned YELLOW_T  = 4,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned PREEMPT_T = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sensor_north,
    input  logic               sensor_east,
    input  logic               sensor_south,
    input  logic               sensor_west,
    input  logic               emrg,
    input  logic               alert1,
    input  logic               alert2,
    input  logic [DIR_W-1:0]   pre_dir,
    output logic [NUM_DIR-1:0] grant,
    output logic [1:0]         lamp,
    output logic               all_red,
    output logic               ambulance,
    output logic               police,
    output logic [CNT_W-1:0]   count,
    output logic               phase_done
);

    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PRE_LOAD    = CNT_W'(PREEMPT_T - 1);
    // Gap-out allowed once at least MIN_T green cycles have elapsed.
    localparam logic [CNT_W-1:0] GAP_LIM     = CNT_W'(GREEN_T - MIN_T);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DIR_W-1:0]   ptr_q, ptr_d;
    preempt_t           pre_q, pre_d;
    logic [NUM_DIR-1:0] grant_q, grant_d;
    logic [1:0]         lamp_q, lamp_d;
    logic               all_red_q, all_red_d;
    logic               ambulance_q, ambulance_d;
    logic               police_q, police_d;
    logic               phase_done_q, phase_done_d;

    logic [NUM_DIR-1:0] sensors;
    logic               pre_req;
    src_t               cur_src;
    logic               src_active;
    logic [DIR_W-1:0]   rr_next;
    logic               rr_any;

    assign sensors = {sensor_west, sensor_south, sensor_east, sensor_north};
    assign pre_req = emrg | alert1 | alert2;

    // Highest-priority active request.
    always_comb begin
        cur_src = SRC_ALERT2;
        if (emrg) begin
            cur_src = SRC_EMRG;
        end else if (alert1) begin
            cur_src = SRC_ALERT1;
        end
    end

    // Whether the latched preempt source is still asserted.
    always_comb begin
        src_active = 1'b0;
        case (pre_q.src)
            SRC_EMRG:   src_active = emrg;
            SRC_ALERT1: src_active = alert1;
            SRC_ALERT2: src_active = alert2;
            default:    src_active = 1'b0;
        endcase
    end

    traffic_rr_pick u_rr_pick (
        .ptr  (ptr_q),
        .req  (sensors),
        .next (rr_next),
        .any  (rr_any)
    );

    // Next-state, counter, pointer and preempt latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        pre_d   = pre_q;

        case (state_q)
            ALL_RED: begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else if (pre_req) begin
                    state_d = PREEMPT;
                    pre_d   = '{src: cur_src, dir: pre_dir};
                    count_d = PRE_LOAD;
                end else if (rr_any) begin
                    state_d = GREEN;
                    ptr_d   = rr_next;
                    count_d = GREEN_LOAD;
                end
            end

            GREEN: begin
                if (pre_req && (cur_src != SRC_ALERT2) && (pre_dir == ptr_q)) begin
                    // Target is already green: hand over without clearance.
                    state_d = PREEMPT;
                    pre_d   = '{src: cur_src, dir: pre_dir};
                    count_d = PRE_LOAD;
                end else if (pre_req || (count_q == '0) ||
                             (!sensors[ptr_q] && (count_q <= GAP_LIM))) begin
                    state_d = YELLOW;
                    count_d = YELLOW_LOAD;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            YELLOW: begin
                if (count_q == '0) begin
                    state_d = ALL_RED;
                    count_d = ALLRED_LOAD;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            PREEMPT: begin
                if (pre_req && (cur_src < pre_q.src)) begin
                    if ((pre_q.src != SRC_ALERT2) && (pre_dir == pre_q.dir)) begin
                        pre_d.src = cur_src;
                        count_d   = PRE_LOAD;
                    end else if (pre_q.src == SRC_ALERT2) begin
                        // Nothing is lit during all-stop, so no yellow is needed.
                        state_d = ALL_RED;
                        count_d = ALLRED_LOAD;
                    end else begin
                        state_d = YELLOW;
                        count_d = YELLOW_LOAD;
                    end
                end else if (src_active) begin
                    count_d = PRE_LOAD;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else if (pre_q.src == SRC_ALERT2) begin
                    state_d = ALL_RED;
                    count_d = ALLRED_LOAD;
                end else begin
                    state_d = YELLOW;
                    count_d = YELLOW_LOAD;
                end
            end

            default: begin
                state_d = ALL_RED;
                count_d = ALLRED_LOAD;
            end
        endcase
    end

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        grant_d      = '0;
        lamp_d       = LAMP_RED;
        ambulance_d  = 1'b0;
        police_d     = 1'b0;
        phase_done_d = (state_q == YELLOW) && (state_d == ALL_RED);

        case (state_d)
            GREEN: begin
                grant_d = dir_onehot(ptr_d);
                lamp_d  = LAMP_GREEN;
            end
            YELLOW: begin
                // Keep whichever approach was green (sensor-served or preempt).
                grant_d = grant_q;
                lamp_d  = LAMP_YELLOW;
            end
            PREEMPT: begin
                if (pre_d.src != SRC_ALERT2) begin
                    grant_d = dir_onehot(pre_d.dir);
                    lamp_d  = LAMP_GREEN;
                end
                ambulance_d = (pre_d.src == SRC_EMRG);
                police_d    = (pre_d.src != SRC_EMRG);
            end
            default: begin
                grant_d = '0;
                lamp_d  = LAMP_RED;
            end
        endcase

        all_red_d = (lamp_d == LAMP_RED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ALL_RED;
            count_q      <= ALLRED_LOAD;
            ptr_q        <= DIR_W_IDX;
            pre_q        <= '{src: SRC_EMRG, dir: DIR_N};
            grant_q      <= '0;
            lamp_q       <= LAMP_RED;
            all_red_q    <= 1'b1;
            ambulance_q  <= 1'b0;
            police_q     <= 1'b0;
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            ptr_q        <= ptr_d;
            pre_q        <= pre_d;
            grant_q      <= grant_d;
            lamp_q       <= lamp_d;
            all_red_q    <= all_red_d;
            ambulance_q  <= ambulance_d;
            police_q     <= police_d;
            phase_done_q <= phase_done_d;
        end
    end

    assign grant      = grant_q;
    assign lamp       = lamp_q;
    assign all_red    = all_red_q;
    assign ambulance  = ambulance_q;
    assign police     = police_q;
    assign count      = count_q;
    assign phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler.
// Input segments with expected outputs are listed up front; each segment is
// expanded per cycle, expectations are queued as inputs are driven and
// popped one cycle later when the registered outputs settle.
module tb_traffic_phase_scheduler;

    localparam int GRN_T = 20;
    localparam int MIN_G = 6;
    localparam int YEL_T = 4;
    localparam int AR_T  = 2;
    localparam int PRE_T = 10;

    localparam logic [3:0] G0 = 4'b0000;
    localparam logic [3:0] GN = 4'b0001;
    localparam logic [3:0] GE = 4'b0010;
    localparam logic [3:0] GS = 4'b0100;
    localparam logic [3:0] GW = 4'b1000;
    localparam logic [3:0] SF = 4'b1111;
    localparam logic [3:0] SSW = 4'b1100;

    localparam logic [1:0] LR = 2'b00;
    localparam logic [1:0] LG = 2'b01;
    localparam logic [1:0] LY = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sens = 4'b0000;
    logic       emrg = 1'b0;
    logic       alert1 = 1'b0;
    logic       alert2 = 1'b0;
    logic [1:0] pre_dir = 2'd0;
    logic [3:0] grant;
    logic [1:0] lamp;
    logic       all_red;
    logic       ambulance;
    logic       police;
    logic [4:0] count;
    logic       phase_done;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .GREEN_T   (GRN_T),
        .MIN_T     (MIN_G),
        .YELLOW_T  (YEL_T),
        .ALLRED_T  (AR_T),
        .PREEMPT_T (PRE_T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_north (sens[0]),
        .sensor_east  (sens[1]),
        .sensor_south (sens[2]),
        .sensor_west  (sens[3]),
        .emrg         (emrg),
        .alert1       (alert1),
        .alert2       (alert2),
        .pre_dir      (pre_dir),
        .grant        (grant),
        .lamp         (lamp),
        .all_red      (all_red),
        .ambulance    (ambulance),
        .police       (police),
        .count        (count),
        .phase_done   (phase_done)
    );

    typedef struct {
        logic       rst;
        logic [3:0] sens;
        logic       emrg;
        logic       a1;
        logic       a2;
        logic [1:0] dir;
        int         len;
        logic [3:0] grant;
        logic [1:0] lamp;
        logic       amb;
        logic       pol;
        logic       pd;
        int         cnt0;   // count on first cycle, then runs down; -1 = unchecked
    } vec_t;

    typedef struct {
        int         id;
        int         cyc;
        logic [3:0] grant;
        logic [1:0] lamp;
        logic       amb;
        logic       pol;
        logic       pd;
        int         cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t sv(input logic [3:0] s, input logic em, input logic a1,
                                input logic a2, input logic [1:0] d, input int len,
                                input logic [3:0] g, input logic [1:0] l, input logic am,
                                input logic po, input logic pd, input int c0);
        vec_t x;
        x.rst = 1'b1; x.sens = s; x.emrg = em; x.a1 = a1; x.a2 = a2; x.dir = d;
        x.len = len; x.grant = g; x.lamp = l; x.amb = am; x.pol = po; x.pd = pd;
        x.cnt0 = c0;
        return x;
    endfunction

    function automatic vec_t rv();
        vec_t x;
        x = sv(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1, G0, LR, 1'b0, 1'b0, 1'b0, AR_T - 1);
        x.rst = 1'b0;
        return x;
    endfunction

    task automatic add_reset();
        vecs.push_back(rv());
        vecs.push_back(rv());
    endtask

    // Full sensor-served phase: green, yellow, all-red with phase_done.
    task automatic add_phase(input logic [3:0] s, input logic [3:0] g);
        vecs.push_back(sv(s, 0, 0, 0, 0, GRN_T, g, LG, 0, 0, 0, GRN_T - 1));
        vecs.push_back(sv(s, 0, 0, 0, 0, YEL_T, g, LY, 0, 0, 0, YEL_T - 1));
        vecs.push_back(sv(s, 0, 0, 0, 0, AR_T, G0, LR, 0, 0, 1, AR_T - 1));
    endtask

    task automatic run_vec(input vec_t x, input int id);
        exp_t e;
        for (int i = 0; i < x.len; i++) begin
            @(negedge clk);
            rst     = x.rst;
            sens    = x.sens;
            emrg    = x.emrg;
            alert1  = x.a1;
            alert2  = x.a2;
            pre_dir = x.dir;
            e.id    = id;
            e.cyc   = i;
            e.grant = x.grant;
            e.lamp  = x.lamp;
            e.amb   = x.amb;
            e.pol   = x.pol;
            e.pd    = x.pd && (i == 0);
            if (x.cnt0 < 0) e.cnt = -1;
            else if (x.cnt0 - i < 0) e.cnt = 0;
            else e.cnt = x.cnt0 - i;
            sb_q.push_back(e);
        end
    endtask

    initial begin
        // All sensors high: N, E, S, W, then N again.
        add_reset();
        vecs.push_back(sv(SF, 0, 0, 0, 0, 1, G0, LR, 0, 0, 0, 0));
        add_phase(SF, GN);
        add_phase(SF, GE);
        add_phase(SF, GS);
        add_phase(SF, GW);
        vecs.push_back(sv(SF, 0, 0, 0, 0, 3, GN, LG, 0, 0, 0, GRN_T - 1));

        // Only South and West request: they alternate.
        add_reset();
        vecs.push_back(sv(SSW, 0, 0, 0, 0, 1, G0, LR, 0, 0, 0, 0));
        add_phase(SSW, GS);
        add_phase(SSW, GW);
        add_phase(SSW, GS);
        vecs.push_back(sv(SSW, 0, 0, 0, 0, 3, GW, LG, 0, 0, 0, GRN_T - 1));

        // East gap-out: early drop waits for MIN_T, late drop yellows at once.
        add_reset();
        vecs.push_back(sv(GE, 0, 0, 0, 0, 1, G0, LR, 0, 0, 0, 0));
        vecs.push_back(sv(GE, 0, 0, 0, 0, 3, GE, LG, 0, 0, 0, GRN_T - 1));
        vecs.push_back(sv(G0, 0, 0, 0, 0, 3, GE, LG, 0, 0, 0, GRN_T - 4));
        vecs.push_back(sv(G0, 0, 0, 0, 0, YEL_T, GE, LY, 0, 0, 0, YEL_T - 1));
        vecs.push_back(sv(G0, 0, 0, 0, 0, 5, G0, LR, 0, 0, 1, AR_T - 1));
        vecs.push_back(sv(GE, 0, 0, 0, 0, 10, GE, LG, 0, 0, 0, GRN_T - 1));
        vecs.push_back(sv(G0, 0, 0, 0, 0, YEL_T, GE, LY, 0, 0, 0, YEL_T - 1));
        vecs.push_back(sv(G0, 0, 0, 0, 0, 3, G0, LR, 0, 0, 1, AR_T - 1));

        // Ambulance to South during North green, held 30 cycles.
        add_reset();
        vecs.push_back(sv(SF, 0, 0, 0, 0, 1, G0, LR, 0, 0, 0, 0));
        vecs.push_back(sv(SF, 0, 0, 0, 0, 5, GN, LG, 0, 0, 0, GRN_T - 1));
        vecs.push_back(sv(SF, 1, 0, 0, 2, YEL_T, GN, LY, 0, 0, 0, YEL_T - 1));
        vecs.push_back(sv(SF, 1, 0, 0, 2, AR_T, G0, LR, 0, 0, 1, AR_T - 1));
        vecs.push_back(sv(SF, 1, 0, 0, 2, 30 - YEL_T - AR_T, GS, LG, 1, 0, 0, -1));
        vecs.push_back(sv(SF, 0, 0, 0, 2, PRE_T - 1, GS, LG, 1, 0, 0, PRE_T - 2));
        vecs.push_back(sv(SF, 0, 0, 0, 0, YEL_T, GS, LY, 0, 0, 0, YEL_T - 1));
        vecs.push_back(sv(SF, 0, 0, 0, 0, AR_T, G0, LR, 0, 0, 1, AR_T - 1));
        vecs.push_back(sv(SF, 0, 0, 0, 0, 3, GE, LG, 0, 0, 0, GRN_T - 1));

        // All-stop during West green, then police green to West during West green.
        add_reset();
        vecs.push_back(sv(GW, 0, 0, 0, 0, 1, G0, LR, 0, 0, 0, 0));
        vecs.push_back(sv(GW, 0, 0, 0, 0, 3, GW, LG, 0, 0, 0, GRN_T - 1));
        vecs.push_back(sv(GW, 0, 0, 1, 0, YEL_T, GW, LY, 0, 0, 0, YEL_T - 1));
        vecs.push_back(sv(GW, 0, 0, 1, 0, AR_T, G0, LR, 0, 0, 1, AR_T - 1));
        vecs.push_back(sv(GW, 0, 0, 1, 0, 5, G0, LR, 0, 1, 0, -1));
        vecs.push_back(sv(GW, 0, 0, 0, 0, PRE_T - 1, G0, LR, 0, 1, 0, PRE_T - 2));
        vecs.push_back(sv(GW, 0, 0, 0, 0, AR_T, G0, LR, 0, 0, 0, AR_T - 1));
        vecs.push_back(sv(GW, 0, 0, 0, 0, 3, GW, LG, 0, 0, 0, GRN_T - 1));
        vecs.push_back(sv(GW, 0, 1, 0, 3, 5, GW, LG, 0, 1, 0, -1));
        vecs.push_back(sv(GW, 0, 0, 0, 3, PRE_T - 1, GW, LG, 0, 1, 0, PRE_T - 2));
        vecs.push_back(sv(GW, 0, 0, 0, 0, YEL_T, GW, LY, 0, 0, 0, YEL_T - 1));
        vecs.push_back(sv(GW, 0, 0, 0, 0, AR_T, G0, LR, 0, 0, 1, AR_T - 1));
        vecs.push_back(sv(GW, 0, 0, 0, 0, 2, GW, LG, 0, 0, 0, GRN_T - 1));

        // Reset pulse in the middle of yellow.
        add_reset();
        vecs.push_back(sv(SF, 0, 0, 0, 0, 1, G0, LR, 0, 0, 0, 0));
        vecs.push_back(sv(SF, 0, 0, 0, 0, GRN_T, GN, LG, 0, 0, 0, GRN_T - 1));
        vecs.push_back(sv(SF, 0, 0, 0, 0, 2, GN, LY, 0, 0, 0, YEL_T - 1));
        vecs.push_back(rv());
        vecs.push_back(sv(SF, 0, 0, 0, 0, 1, G0, LR, 0, 0, 0, 0));
        vecs.push_back(sv(SF, 0, 0, 0, 0, 3, GN, LG, 0, 0, 0, GRN_T - 1));

        fork
            forever begin
                exp_t e;
                logic ok;
                @(posedge clk);
                #1;
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    n_checks++;
                    ok = (grant == e.grant) && (lamp == e.lamp) &&
                         (all_red == (e.lamp == LR)) && (ambulance == e.amb) &&
                         (police == e.pol) && (phase_done == e.pd) &&
                         ((e.cnt < 0) || (count == 5'(e.cnt)));
                    if (!ok) begin
                        n_errors++;
                        $display("FAIL vec%0d.%0d grant/lamp/ar/amb/pol/pd/cnt got %b/%b/%b/%b/%b/%b/%0d want %b/%b/%b/%b/%b/%b/%0d",
                                 e.id, e.cyc, grant, lamp, all_red, ambulance, police,
                                 phase_done, count, e.grant, e.lamp, (e.lamp == LR),
                                 e.amb, e.pol, e.pd, e.cnt);
                    end
                end
            end
        join_none

        for (int v = 0; v < vecs.size(); v++) begin
            run_vec(vecs[v], v);
            // Reset acts without a clock edge.
            if (!vecs[v].rst) begin
                #1;
                n_checks++;
                if ((grant != G0) || (lamp != LR) || (all_red != 1'b1) ||
                    (ambulance != 1'b0) || (police != 1'b0) || (phase_done != 1'b0) ||
                    (count != 5'(AR_T - 1))) begin
                    n_errors++;
                    $display("FAIL async_reset vec%0d got grant=%b lamp=%b ar=%b amb=%b pol=%b pd=%b cnt=%0d want 0000/00/1/0/0/0/%0d",
                             v, grant, lamp, all_red, ambulance, police, phase_done,
                             count, AR_T - 1);
                end
            end
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got %0d pending want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
